// File: rtl/mc_pkg.sv
// mc_pkg: shared parameters, FSM state type and helper functions for the
// motion-compensation blocks (encoder-side motion_compensation and the
// decoder-side mc_reconstruct).
//   MB_SIZE        block edge in pixels (power of two)
//   PIXEL_WIDTH    unsigned pixel width; residuals are signed PIXEL_WIDTH+1
//   REF_FRAME_SIZE square reference frame edge in pixels
//   MV_WIDTH       unsigned integer-pel motion vector component width
package mc_pkg;

    localparam int MB_SIZE        = 4;
    localparam int PIXEL_WIDTH    = 8;
    localparam int REF_FRAME_SIZE = 8;
    localparam int MV_WIDTH       = 6;

    localparam int N_PIX   = MB_SIZE * MB_SIZE;
    localparam int COORD_W = $clog2(REF_FRAME_SIZE);
    localparam int MB_W    = $clog2(MB_SIZE);
    localparam int IDX_W   = $clog2(N_PIX);
    localparam int CNT_W   = $clog2(N_PIX + 1);
    localparam int SUM_W   = PIXEL_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } mc_state_e;

    // Saturate a signed prediction+residual sum to the pixel range.
    // The sum lies in [-2^PW, 2^(PW+1)-2], so the sign bit flags underflow
    // and bit PW (on a non-negative sum) flags overflow.
    function automatic logic [PIXEL_WIDTH-1:0] clip_pixel(input logic [SUM_W-1:0] sum);
        if (sum[SUM_W-1])
            return '0;
        else if (sum[PIXEL_WIDTH])
            return '1;
        else
            return sum[PIXEL_WIDTH-1:0];
    endfunction

    // Edge-clamp a window coordinate computed in MV_WIDTH+1 bits (no wrap).
    function automatic logic [COORD_W-1:0] clamp_coord(input logic [MV_WIDTH:0] v);
        if (v > (MV_WIDTH+1)'(REF_FRAME_SIZE - 1))
            return COORD_W'(REF_FRAME_SIZE - 1);
        else
            return v[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/mc_pred_buffer.sv
// mc_pred_buffer: N_PIX x PIXEL_WIDTH register file holding the prefetched
// prediction window in raster order.
//   clk, reset  clock / asynchronous active-low reset
//   we, waddr, wdata   synchronous write port
//   raddr, rdata       asynchronous (combinational) read port
module mc_pred_buffer
    import mc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [IDX_W-1:0]       waddr,
    input  logic [PIXEL_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]       raddr,
    output logic [PIXEL_WIDTH-1:0] rdata
);

    logic [PIXEL_WIDTH-1:0] mem [N_PIX];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_PIX; k++) mem[k] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mc_reconstruct.sv
// mc_reconstruct: rebuilds one MB_SIZE x MB_SIZE block as
// recon = clip(pred + residual), pred being the reference window displaced by
// (mv_x, mv_y) with edge clamping. The window is prefetched into
// mc_pred_buffer, then residuals stream in and reconstructed pixels stream out.
//   clk, reset                   clock / asynchronous active-low reset
//   start, mv_x, mv_y            block request; mv latched when start accepted in IDLE
//   busy, done                   busy while not IDLE; done pulses for one cycle at the end
//   ref_rd_en/row/col, ref_rd_data  reference read port, data one cycle after strobe
//   res_valid/res_ready/res_data    residual input stream
//   recon_valid/recon_ready/recon_data  reconstructed pixel output stream
//   fsm_state                    current FSM state for observation
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid & ready are both high; the producer holds valid and data stable until
// that transfer, and ready may depend combinationally on the consumer side.
module mc_reconstruct
    import mc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [MV_WIDTH-1:0]    mv_x,
    input  logic [MV_WIDTH-1:0]    mv_y,
    output logic                   busy,
    output logic                   done,
    output logic                   ref_rd_en,
    output logic [COORD_W-1:0]     ref_rd_row,
    output logic [COORD_W-1:0]     ref_rd_col,
    input  logic [PIXEL_WIDTH-1:0] ref_rd_data,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [PIXEL_WIDTH:0]   res_data,
    output logic                   recon_valid,
    input  logic                   recon_ready,
    output logic [PIXEL_WIDTH-1:0] recon_data,
    output mc_state_e              fsm_state
);

    localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N_PIX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mc_state_e              state, state_next;
    logic [MV_WIDTH-1:0]    mv_x_q, mv_y_q;
    logic [CNT_W-1:0]       issue_cnt;   // reads issued during FETCH
    logic [CNT_W-1:0]       res_cnt;     // residuals accepted
    logic [CNT_W-1:0]       out_cnt;     // recon pixels handed downstream
    logic                   wr_en_q;     // read strobe delayed to match read data
    logic [IDX_W-1:0]       wr_idx_q;
    logic                   recon_valid_q;
    logic [PIXEL_WIDTH-1:0] recon_data_q;
    logic [PIXEL_WIDTH-1:0] pred_pix;
    logic                   res_hs, out_hs;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            // The extra cycle at issue_cnt == N lets the last read land in the buffer.
            FETCH: if (issue_cnt == CNT_N) state_next = RUN;
            RUN:   if (out_hs && out_cnt == CNT_LAST) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        ref_rd_en = (state == FETCH) && (issue_cnt < CNT_N);
        // Single output register: accept a residual whenever the register is
        // empty or being drained in the same cycle.
        res_ready = (state == RUN) && (res_cnt < CNT_N) && (!recon_valid_q || recon_ready);
    end

    assign fsm_state = state;

    // ---------------- Read address generation with edge clamp ----------------
    // MB_SIZE is a power of two, so the raster index splits into row/col bits.
    logic [IDX_W-1:0] issue_idx;
    assign issue_idx  = issue_cnt[IDX_W-1:0];
    assign ref_rd_row = clamp_coord({1'b0, mv_y_q} + (MV_WIDTH+1)'(issue_idx[IDX_W-1:MB_W]));
    assign ref_rd_col = clamp_coord({1'b0, mv_x_q} + (MV_WIDTH+1)'(issue_idx[MB_W-1:0]));

    // ---------------- Prediction buffer ----------------
    mc_pred_buffer u_pred_buffer (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en_q),
        .waddr (wr_idx_q),
        .wdata (ref_rd_data),
        .raddr (res_cnt[IDX_W-1:0]),
        .rdata (pred_pix)
    );

    // ---------------- Adder / clip ----------------
    logic [SUM_W-1:0] sum;
    assign sum    = {2'b00, pred_pix} + {res_data[PIXEL_WIDTH], res_data};
    assign res_hs = res_valid && res_ready;
    assign out_hs = recon_valid_q && recon_ready;

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mv_x_q        <= '0;
            mv_y_q        <= '0;
            issue_cnt     <= '0;
            res_cnt       <= '0;
            out_cnt       <= '0;
            wr_en_q       <= 1'b0;
            wr_idx_q      <= '0;
            recon_valid_q <= 1'b0;
            recon_data_q  <= '0;
        end else begin
            wr_en_q  <= ref_rd_en;
            wr_idx_q <= issue_idx;

            if (state == IDLE && start) begin
                mv_x_q    <= mv_x;
                mv_y_q    <= mv_y;
                issue_cnt <= '0;
                res_cnt   <= '0;
                out_cnt   <= '0;
            end

            if (state == FETCH && issue_cnt < CNT_N)
                issue_cnt <= issue_cnt + CNT_ONE;

            // A new residual reloads the register even if it drains this cycle,
            // so valid stays high through back-to-back transfers.
            if (res_hs) begin
                recon_data_q  <= clip_pixel(sum);
                recon_valid_q <= 1'b1;
                res_cnt       <= res_cnt + CNT_ONE;
            end else if (out_hs) begin
                recon_valid_q <= 1'b0;
            end

            if (out_hs)
                out_cnt <= out_cnt + CNT_ONE;
        end
    end

    assign recon_valid = recon_valid_q;
    assign recon_data  = recon_data_q;

endmodule

// File: tb/tb_mc_reconstruct.sv
module tb_mc_reconstruct;
    import mc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic                   start;
    logic [MV_WIDTH-1:0]    mv_x, mv_y;
    logic                   busy, done, ref_rd_en;
    logic [COORD_W-1:0]     ref_rd_row, ref_rd_col;
    logic [PIXEL_WIDTH-1:0] ref_rd_data;
    logic                   res_valid, res_ready;
    logic [PIXEL_WIDTH:0]   res_data;
    logic                   recon_valid, recon_ready;
    logic [PIXEL_WIDTH-1:0] recon_data;
    mc_state_e              fsm_state;

    mc_reconstruct dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mv_x        (mv_x),
        .mv_y        (mv_y),
        .busy        (busy),
        .done        (done),
        .ref_rd_en   (ref_rd_en),
        .ref_rd_row  (ref_rd_row),
        .ref_rd_col  (ref_rd_col),
        .ref_rd_data (ref_rd_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .recon_valid (recon_valid),
        .recon_ready (recon_ready),
        .recon_data  (recon_data),
        .fsm_state   (fsm_state)
    );

    // ---------------- reference frame model ----------------
    logic [7:0] ref_mem [8][8];
    logic [5:0] rd_log [$];
    int         res_vals [16];

    always @(posedge clk) begin
        if (ref_rd_en) begin
            ref_rd_data <= ref_mem[ref_rd_row][ref_rd_col];
            rd_log.push_back({ref_rd_row, ref_rd_col});
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    // Reference pixel straight from the definition recon = clip(ref window + residual).
    function automatic int model_pix(input int mvx, input int mvy, input int k);
        int r, c, s;
        r = clamp7(mvy + k / 4);
        c = clamp7(mvx + k % 4);
        s = int'(ref_mem[r][c]) + res_vals[k];
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic fill_ref_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) ref_mem[r][c] = 8'(8 * r + c);
    endtask

    task automatic fill_ref_const(input int v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) ref_mem[r][c] = 8'(v);
    endtask

    task automatic fill_ref_rand();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) ref_mem[r][c] = 8'($urandom_range(255));
    endtask

    task automatic fill_res_const(input int v);
        for (int k = 0; k < 16; k++) res_vals[k] = v;
    endtask

    task automatic fill_res_rand();
        for (int k = 0; k < 16; k++) res_vals[k] = int'($urandom_range(511)) - 256;
    endtask

    // ---------------- driver: one block ----------------
    task automatic do_block(input int mvx, input int mvy, input int ready_pct,
                            input int valid_pct, input bit glitch, input int abort_after,
                            input bit check_lat, input bit check_tp);
        int cycles, cyc, res_idx, out_cnt, first_hs, last_hs;
        bit pending, stalled, seen_done, aborted, glitched;
        logic [7:0] held, exp_v;

        exp_q.delete();
        rd_log.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(model_pix(mvx, mvy, k)));

        @(negedge clk);
        start       = 1'b1;
        mv_x        = 6'(mvx);
        mv_y        = 6'(mvy);
        res_valid   = 1'b0;
        recon_ready = 1'b1;

        cycles = 0;
        while (cycles < 40) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            #1;
            if (cycles == 1) check("busy_in_fetch", busy, 1);
            if (res_ready) break;
        end
        if (check_lat) check("start_to_ready_latency", cycles, 18);

        res_idx = 0; out_cnt = 0; cyc = 0; first_hs = -1; last_hs = -1;
        pending = 0; stalled = 0; seen_done = 0; aborted = 0; glitched = 0; held = '0;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (glitch && out_cnt == 3 && !glitched) begin
                start    = 1'b1;
                mv_x     = 6'(mvx + 3);
                mv_y     = 6'(mvy + 2);
                glitched = 1;
            end
            recon_ready = ($urandom_range(99) < ready_pct);
            if (!pending && res_idx < 16 && $urandom_range(99) < valid_pct) pending = 1;
            res_valid = pending;
            res_data  = 9'(res_vals[(res_idx < 16) ? res_idx : 0]);
            #1;
            if (abort_after >= 0 && out_cnt == abort_after) begin
                reset = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_ref_rd_en", ref_rd_en, 0);
                check("abort_res_ready", res_ready, 0);
                check("abort_recon_valid", recon_valid, 0);
                check("abort_recon_data", recon_data, 0);
                check("abort_state", fsm_state, IDLE);
                reset     = 1'b1;
                res_valid = 1'b0;
                aborted   = 1;
                break;
            end
            if (done === 1'b1) begin
                seen_done = 1;
                break;
            end
            if (stalled) begin
                check("stall_valid_held", recon_valid, 1);
                check("stall_data_held", recon_data, held);
            end
            if (res_valid && res_ready) begin
                res_idx++;
                pending = 0;
            end
            if (recon_valid && recon_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_recon_pixel", out_cnt, 16);
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("recon_pix_%0d", out_cnt), recon_data, exp_v);
                end
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                out_cnt++;
            end
            stalled = recon_valid && !recon_ready;
            held    = recon_data;
        end
        res_valid = 1'b0;
        start     = 1'b0;

        if (!aborted) begin
            check("done_seen", seen_done, 1);
            check("recon_count", out_cnt, 16);
            check("res_count", res_idx, 16);
            check("busy_during_done", busy, 1);
            @(negedge clk);
            #1;
            check("done_one_cycle", done, 0);
            check("busy_after_done", busy, 0);
            check("read_count", rd_log.size(), 16);
            for (int k = 0; k < 16 && k < rd_log.size(); k++)
                check($sformatf("read_addr_%0d", k), rd_log[k],
                      {3'(clamp7(mvy + k / 4)), 3'(clamp7(mvx + k % 4))});
            if (check_tp) check("throughput", last_hs - first_hs, 15);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        mv_x        = '0;
        mv_y        = '0;
        res_valid   = 1'b0;
        res_data    = '0;
        recon_ready = 1'b0;
        ref_rd_data = '0;
        fill_ref_ramp();
        fill_res_const(0);

        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ref_rd_en", ref_rd_en, 0);
        check("reset_res_ready", res_ready, 0);
        check("reset_recon_valid", recon_valid, 0);
        check("reset_recon_data", recon_data, 0);
        check("reset_state", fsm_state, IDLE);
        @(negedge clk);
        reset = 1'b1;

        // Ramp frame, zero residual, mv=(1,3); latency and full throughput.
        do_block(1, 3, 100, 100, 0, -1, 1, 1);

        // Saturation cases.
        fill_ref_const(250); fill_res_const(10);
        do_block(2, 2, 100, 100, 0, -1, 0, 0);
        fill_ref_const(5); fill_res_const(-10);
        do_block(0, 4, 100, 100, 0, -1, 0, 0);
        fill_ref_const(100); fill_res_const(-256);
        do_block(4, 0, 100, 100, 0, -1, 0, 0);

        // Window past the frame edge clamps to the last row/column.
        fill_ref_ramp(); fill_res_const(0);
        do_block(6, 6, 100, 100, 0, -1, 0, 0);

        // Random data with random backpressure on both streams.
        for (int t = 0; t < 3; t++) begin
            fill_ref_rand(); fill_res_rand();
            do_block(int'($urandom_range(9)), int'($urandom_range(9)), 50, 60, 0, -1, 0, 0);
        end

        // Start during RUN with a different mv is ignored.
        fill_ref_rand(); fill_res_rand();
        do_block(2, 1, 70, 80, 1, -1, 0, 0);

        // Reset after 5 recon pixels, then a clean block.
        fill_ref_rand(); fill_res_rand();
        do_block(0, 0, 100, 100, 0, 5, 0, 0);
        fill_ref_rand(); fill_res_rand();
        do_block(3, 2, 100, 100, 0, -1, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
